// File: rtl/lfsr_cipher_pkg.sv
// Shared LFSR stream-cipher definitions; the transmit side imports the same
// package so both keystreams are guaranteed identical.
package lfsr_cipher_pkg;

    localparam int unsigned     LFSR_W       = 8;
    localparam logic [7:0]      DEFAULT_SEED = 8'hA5;
    localparam logic [7:0]      DEFAULT_TAPS = 8'hB8;

    // Receive phase decoded from bit counter and output-hold status.
    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_COMPLETE,
        ST_HOLD
    } dec_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] state,
        input logic [LFSR_W-1:0] taps
    );
        return {state[LFSR_W-2:0], ^(state & taps)};
    endfunction

endpackage

// File: rtl/lfsr_stream_decryptor_if.sv
// Ciphertext bit stream in, plaintext byte stream out, both valid/ready.
interface lfsr_stream_decryptor_if;

    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/lfsr_keystream_gen.sv
// Fibonacci LFSR keystream source; advances only when asked, reloads on load.
module lfsr_keystream_gen
    import lfsr_cipher_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
    parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              advance,
    output logic              ks_bit,
    output logic [LFSR_W-1:0] state
);

    logic [LFSR_W-1:0] state_q, state_d;

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = SEED;
        end else if (advance) begin
            state_d = lfsr_next(state_q, TAPS);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign state  = state_q;
    assign ks_bit = state_q[LFSR_W-1];

`ifndef SYNTHESIS
    // An all-zero seed locks the LFSR at zero and yields no keystream.
    a_seed_nonzero: assert property (@(posedge clk) SEED != '0)
        else $error("lfsr_keystream_gen: SEED must be nonzero");
`endif

endmodule

// File: rtl/lfsr_stream_decryptor.sv
// Receive end of the LFSR stream cipher: XORs ciphertext bits with the
// keystream, packs plaintext LSB first and offers bytes on a valid/ready port.
module lfsr_stream_decryptor
    import lfsr_cipher_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED,
    parameter logic [LFSR_W-1:0] TAPS = DEFAULT_TAPS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sync,
    lfsr_stream_decryptor_if.slave   bus,
    output logic [LFSR_W-1:0]        lfsr_state,
    output logic [15:0]              byte_count
);

    logic [2:0]  bit_cnt_q,   bit_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [6:0]  partial_q,   partial_d;
    logic [7:0]  out_data_q,  out_data_d;
    logic [15:0] count_q,     count_d;

    dec_state_e  phase;
    logic        in_ready;
    logic        accept;
    logic        pop;
    logic        ks_bit;
    logic        p_bit;

    lfsr_keystream_gen #(
        .SEED (SEED),
        .TAPS (TAPS)
    ) u_ks (
        .clk     (clk),
        .rst     (rst),
        .load    (sync),
        .advance (accept),
        .ks_bit  (ks_bit),
        .state   (lfsr_state)
    );

    assign accept = bus.in_valid & in_ready;
    assign pop    = out_valid_q & bus.out_ready;
    assign p_bit  = bus.in_bit ^ ks_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            partial_q   <= '0;
            out_data_q  <= '0;
            count_q     <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            out_valid_q <= out_valid_d;
            partial_q   <= partial_d;
            out_data_q  <= out_data_d;
            count_q     <= count_d;
        end
    end

    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        out_valid_d = out_valid_q;
        partial_d   = partial_q;
        out_data_d  = out_data_q;
        count_d     = count_q;

        // Pop first so a completing bit in the same cycle re-asserts valid.
        if (pop) begin
            out_valid_d = 1'b0;
            count_d     = count_q + 16'd1;
        end

        if (sync) begin
            bit_cnt_d = '0;
            partial_d = '0;
        end else if (accept) begin
            if (bit_cnt_q == 3'd7) begin
                out_data_d  = {p_bit, partial_q};
                out_valid_d = 1'b1;
                bit_cnt_d   = '0;
            end else begin
                for (int unsigned i = 0; i < 7; i++) begin
                    if (bit_cnt_q == 3'(i)) begin
                        partial_d[i] = p_bit;
                    end
                end
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end
    end

    always_comb begin
        phase = ST_COLLECT;
        if (out_valid_q && !bus.out_ready) begin
            phase = ST_HOLD;
        end else if (bit_cnt_q == 3'd7) begin
            phase = ST_COMPLETE;
        end
        // Only the completing bit stalls behind an unconsumed byte.
        in_ready = !rst && !sync && !(phase == ST_HOLD && bit_cnt_q == 3'd7);
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign byte_count    = count_q;

endmodule

// File: tb/tb_lfsr_stream_decryptor.sv
// Self-checking bench for lfsr_stream_decryptor: vector table, directed
// corner sequences and randomized traffic against a queue-based model.
module tb_lfsr_stream_decryptor;

    logic        clk = 1'b0;
    logic        rst;
    logic        sync;
    logic [7:0]  lfsr_state;
    logic [15:0] byte_count;

    lfsr_stream_decryptor_if ifc ();

    lfsr_stream_decryptor #(
        .SEED (8'hA5),
        .TAPS (8'hB8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sync       (sync),
        .bus        (ifc),
        .lfsr_state (lfsr_state),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // Reference model: keystream register, received plaintext bits, held byte.
    int unsigned m_state;
    bit          m_bits[$];
    bit          m_held;
    int unsigned m_data;
    int unsigned m_count;

    typedef struct {
        bit         s;
        bit         v;
        bit         b;
        bit         r;
        bit         exp_ready;
        logic [7:0] exp_lfsr;
        bit         exp_valid;
        logic [7:0] exp_data;
        logic [15:0] exp_count;
    } vec_t;

    vec_t vecs[$];

    function automatic int unsigned ref_next(input int unsigned s);
        int unsigned fb;
        fb = $countones(s & 32'hB8) % 2;
        return ((s << 1) | fb) & 32'hFF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("out_valid",  32'(ifc.out_valid), 32'(m_held));
        chk("out_data",   32'(ifc.out_data),  m_data);
        chk("byte_count", 32'(byte_count),    m_count);
        chk("lfsr_state", 32'(lfsr_state),    m_state);
    endtask

    // Entered just after a rising edge; leaves just after the next one.
    task automatic step(input bit s, input bit v, input bit b, input bit r, output bit rdy);
        bit m_rdy;
        bit p;
        int unsigned d;
        sync          = s;
        ifc.in_valid  = v;
        ifc.in_bit    = b;
        ifc.out_ready = r;
        m_rdy = !s && (m_bits.size() != 7 || !m_held || r);
        @(negedge clk);
        rdy = ifc.in_ready;
        chk("in_ready", 32'(rdy), 32'(m_rdy));
        @(posedge clk);
        if (m_held && r) begin
            m_held  = 1'b0;
            m_count = (m_count + 1) % 65536;
        end
        if (s) begin
            m_state = 32'hA5;
            m_bits.delete();
        end else if (v && m_rdy) begin
            p = b ^ m_state[7];
            m_state = ref_next(m_state);
            m_bits.push_back(p);
            if (m_bits.size() == 8) begin
                d = 0;
                for (int i = 0; i < 8; i++) d += int'(m_bits[i]) << i;
                m_data = d;
                m_held = 1'b1;
                m_bits.delete();
            end
        end
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst           = 1'b1;
        sync          = 1'b0;
        ifc.in_valid  = 1'b1;
        ifc.in_bit    = 1'b0;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        chk("in_ready_in_rst", 32'(ifc.in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst          = 1'b0;
        ifc.in_valid = 1'b0;
        m_state = 32'hA5;
        m_bits.delete();
        m_held  = 1'b0;
        m_data  = 0;
        m_count = 0;
        check_outputs();
    endtask

    task automatic send_byte(input logic [7:0] c, input bit r);
        bit rdy;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, c[i], r, rdy);
    endtask

    initial begin
        bit          rdy;
        logic [7:0]  tmp;

        // Keystream bytes A5/72 with backpressure, stall and pop-on-completion.
        vecs.push_back('{0,1,0,0, 1, 8'h4A, 0, 8'h00, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'h95, 0, 8'h00, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'h2A, 0, 8'h00, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'h54, 0, 8'h00, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'hA9, 0, 8'h00, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'h53, 0, 8'h00, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'hA7, 0, 8'h00, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'h4E, 1, 8'hA5, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'h9D, 1, 8'hA5, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'h3B, 1, 8'hA5, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'h77, 1, 8'hA5, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'hEE, 1, 8'hA5, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'hDD, 1, 8'hA5, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'hBB, 1, 8'hA5, 16'd0});
        vecs.push_back('{0,1,0,0, 1, 8'h76, 1, 8'hA5, 16'd0});
        vecs.push_back('{0,1,0,0, 0, 8'h76, 1, 8'hA5, 16'd0});
        vecs.push_back('{0,1,0,1, 1, 8'hEC, 1, 8'h72, 16'd1});
        vecs.push_back('{0,0,0,1, 1, 8'hEC, 0, 8'h72, 16'd2});

        do_reset();
        chk("reset_lfsr",  32'(lfsr_state),    32'hA5);
        chk("reset_valid", 32'(ifc.out_valid), 32'd0);
        chk("reset_data",  32'(ifc.out_data),  32'd0);
        chk("reset_count", 32'(byte_count),    32'd0);

        foreach (vecs[k]) begin
            step(vecs[k].s, vecs[k].v, vecs[k].b, vecs[k].r, rdy);
            chk($sformatf("vec%0d_ready", k), 32'(rdy),            32'(vecs[k].exp_ready));
            chk($sformatf("vec%0d_lfsr",  k), 32'(lfsr_state),     32'(vecs[k].exp_lfsr));
            chk($sformatf("vec%0d_valid", k), 32'(ifc.out_valid),  32'(vecs[k].exp_valid));
            chk($sformatf("vec%0d_data",  k), 32'(ifc.out_data),   32'(vecs[k].exp_data));
            chk($sformatf("vec%0d_count", k), 32'(byte_count),     32'(vecs[k].exp_count));
        end

        // Decrypt 0E -> AB.
        do_reset();
        send_byte(8'h0E, 1'b1);
        chk("t1_data",  32'(ifc.out_data),  32'hAB);
        chk("t1_valid", 32'(ifc.out_valid), 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, rdy);
        chk("t1_count", 32'(byte_count), 32'd1);

        // Resync drops a partial byte.
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'($urandom_range(1)), 1'b1, rdy);
        step(1'b1, 1'b0, 1'b0, 1'b1, rdy);
        chk("t3_no_byte", 32'(ifc.out_valid), 32'd0);
        chk("t3_lfsr",    32'(lfsr_state),    32'hA5);
        send_byte(8'h00, 1'b0);
        chk("t3_data",  32'(ifc.out_data), 32'hA5);
        chk("t3_count", 32'(byte_count),   32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, rdy);
        chk("t3_count_pop", 32'(byte_count), 32'd1);

        // Sync colliding with a bit, while a byte is pending.
        do_reset();
        send_byte(8'h00, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, rdy);
        step(1'b0, 1'b1, 1'b0, 1'b0, rdy);
        step(1'b1, 1'b1, 1'b1, 1'b0, rdy);
        chk("t5_sync_ready", 32'(rdy),            32'd0);
        chk("t5_sync_lfsr",  32'(lfsr_state),     32'hA5);
        chk("t5_pending",    32'(ifc.out_valid),  32'd1);
        chk("t5_pend_data",  32'(ifc.out_data),   32'hA5);
        tmp = 8'h00;
        send_byte(tmp, 1'b1);
        chk("t5_data", 32'(ifc.out_data), 32'hA5);
        chk("t5_count", 32'(byte_count),  32'd1);

        // Mid-operation reset with a held byte.
        do_reset();
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, rdy);
        do_reset();
        chk("t6_valid", 32'(ifc.out_valid), 32'd0);
        chk("t6_data",  32'(ifc.out_data),  32'd0);
        chk("t6_count", 32'(byte_count),    32'd0);
        chk("t6_lfsr",  32'(lfsr_state),    32'hA5);
        send_byte(8'h00, 1'b1);
        chk("t6_after", 32'(ifc.out_data),  32'hA5);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(63) == 0),
                 ($urandom_range(2) != 0),
                 1'($urandom_range(1)),
                 ($urandom_range(3) != 0),
                 rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
